// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-index, forwarding-select and scoreboard-entry definitions
package core_pkg;

  localparam int REG_W = 4;
  localparam int FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  localparam logic [REG_W-1:0] PC_REG = 4'd15;
  localparam logic [REG_W-1:0] LR_REG = 4'd14;

  // E entry keeps the source indices (needed for forwarding) and the load flag
  // (needed for load-use detection).
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] ra1;
    logic [REG_W-1:0] ra2;
    logic [REG_W-1:0] wa;
    logic             regwrite;
    logic             memtoreg;
    logic             pcsrc;
  } ex_entry_t;

  // M/W entries only need what forwarding and PC-write retirement look at.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wa;
    logic             regwrite;
    logic             pcsrc;
  } wb_entry_t;

  // Forward from the youngest producer (M before W); the PC is never forwarded.
  function automatic logic [FWD_W-1:0] fwd_select(input wb_entry_t m,
                                                  input wb_entry_t w,
                                                  input logic [REG_W-1:0] src);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (src != PC_REG) begin
      if (m.valid && m.regwrite && (m.wa == src)) begin
        sel = FWD_MEM;
      end else if (w.valid && w.regwrite && (w.wa == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode/execute controls in, forwarding/stall/flush controls out
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import core_pkg::*;

  logic [REG_W-1:0] RA1D;
  logic [REG_W-1:0] RA2D;
  logic [REG_W-1:0] WA3D;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             PCSrcD;
  logic             BlWriteD;
  logic             CondExE;
  logic             BranchTakenE;

  logic [FWD_W-1:0] ForwardAE;
  logic [FWD_W-1:0] ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BlWriteD, CondExE, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BlWriteD, CondExE, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_sat_counter.sv
// rtl/hazard_sat_counter.sv - event counter that sticks at all-ones
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Advance on a qualifying cycle unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - E/M/W scoreboard driving forwarding, stalls and flushes
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  ex_entry_t        e_q, e_d;
  wb_entry_t        m_q, m_d;
  wb_entry_t        w_q, w_d;

  logic             ldrstall;
  logic             pc_wr_pend;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Load in E feeding the decode sources, and any R15 write still ahead of W.
  // The load flag is used before condition qualification on purpose (conservative).
  always_comb begin
    ldrstall   = e_q.valid && e_q.memtoreg &&
                 ((e_q.wa == hz.RA1D) || (e_q.wa == hz.RA2D));
    pc_wr_pend = hz.PCSrcD || (e_q.valid && e_q.pcsrc) || (m_q.valid && m_q.pcsrc);
  end

  // Operand bypass selects for the instruction in E
  always_comb begin
    fwd_a = fwd_select(m_q, w_q, e_q.ra1);
    fwd_b = fwd_select(m_q, w_q, e_q.ra2);
  end

  // Stall/flush; a taken branch overrides the load-use hold of D
  always_comb begin
    stall_f = ldrstall | pc_wr_pend;
    stall_d = ldrstall & ~hz.BranchTakenE;
    flush_e = ldrstall | hz.BranchTakenE;
    flush_d = pc_wr_pend | (w_q.valid & w_q.pcsrc) | hz.BranchTakenE;
  end

  // Scoreboard next state: D enters E unless bubbled, E results qualified by the condition
  always_comb begin
    e_d = '0;
    if (!flush_e) begin
      e_d.valid    = 1'b1;
      e_d.ra1      = hz.RA1D;
      e_d.ra2      = hz.RA2D;
      e_d.wa       = hz.BlWriteD ? LR_REG : hz.WA3D;
      e_d.regwrite = hz.RegWriteD | hz.BlWriteD;
      e_d.memtoreg = hz.MemtoRegD;
      e_d.pcsrc    = hz.PCSrcD;
    end
    m_d.valid    = e_q.valid;
    m_d.wa       = e_q.wa;
    m_d.regwrite = e_q.regwrite & hz.CondExE;
    m_d.pcsrc    = e_q.pcsrc & hz.CondExE;
    w_d          = m_q;
  end

  // Scoreboard shift register; reset drops every in-flight entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_d),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_d | flush_e),
    .count (flush_cnt)
  );

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit v;
    int ra1;
    int ra2;
    int wa;
    bit rw;
    bit ld;
    bit pc;
  } instr_t;

  typedef struct {
    bit care_fwd;
    int fa;
    int fb;
    int sf;
    int sd;
    int fd;
    int fe;
    int sc;
    int fc;
  } exp_t;

  instr_t pipe [3];   // 0: in E, 1: in M, 2: in W
  int     m_stall;
  int     m_flush;
  exp_t   expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    m_stall = 0;
    m_flush = 0;
  endfunction

  function automatic int mfwd(int src);
    if (src == 15) return 0;
    if (pipe[1].v && pipe[1].rw && pipe[1].wa == src) return 2;
    if (pipe[2].v && pipe[2].rw && pipe[2].wa == src) return 1;
    return 0;
  endfunction

  // One decode cycle: drive at the falling edge, predict outputs, advance the model.
  task automatic step(input int ra1, input int ra2, input int wa, input bit rw, input bit ld,
                      input bit pcs, input bit bl, input bit cond, input bit bt);
    exp_t e;
    bit   lu;
    bit   pend;
    @(negedge clk);
    hif.RA1D         = 4'(ra1);
    hif.RA2D         = 4'(ra2);
    hif.WA3D         = 4'(wa);
    hif.RegWriteD    = rw;
    hif.MemtoRegD    = ld;
    hif.PCSrcD       = pcs;
    hif.BlWriteD     = bl;
    hif.CondExE      = cond;
    hif.BranchTakenE = bt;

    lu   = pipe[0].v && pipe[0].ld && (pipe[0].wa == ra1 || pipe[0].wa == ra2);
    pend = pcs || (pipe[0].v && pipe[0].pc) || (pipe[1].v && pipe[1].pc);
    e.care_fwd = pipe[0].v;
    e.fa = mfwd(pipe[0].ra1);
    e.fb = mfwd(pipe[0].ra2);
    e.sf = int'(lu || pend);
    e.sd = int'(lu && !bt);
    e.fe = int'(lu || bt);
    e.fd = int'(pend || (pipe[2].v && pipe[2].pc) || bt);
    e.sc = m_stall;
    e.fc = m_flush;
    expq.push_back(e);

    if (e.sd != 0 && m_stall < CNT_MAX) m_stall++;
    if ((e.fd != 0 || e.fe != 0) && m_flush < CNT_MAX) m_flush++;
    pipe[2]    = pipe[1];
    pipe[1]    = pipe[0];
    pipe[1].rw = pipe[1].rw && cond;
    pipe[1].pc = pipe[1].pc && cond;
    if (e.fe != 0) pipe[0] = '{default: 0};
    else           pipe[0] = '{1'b1, ra1, ra2, bl ? 14 : wa, rw || bl, ld, pcs};
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic drive_zero();
    hif.RA1D = '0; hif.RA2D = '0; hif.WA3D = '0;
    hif.RegWriteD = 0; hif.MemtoRegD = 0; hif.PCSrcD = 0; hif.BlWriteD = 0;
    hif.CondExE = 0; hif.BranchTakenE = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_fwdA"}, 32'(hif.ForwardAE), 0);
    chk({tag, "_fwdB"}, 32'(hif.ForwardBE), 0);
    chk({tag, "_stallF"}, 32'(hif.StallF), 0);
    chk({tag, "_stallD"}, 32'(hif.StallD), 0);
    chk({tag, "_flushD"}, 32'(hif.FlushD), 0);
    chk({tag, "_flushE"}, 32'(hif.FlushE), 0);
    chk({tag, "_stall_cnt"}, 32'(hif.stall_cnt), 0);
    chk({tag, "_flush_cnt"}, 32'(hif.flush_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_zero();
    model_clear();
    #3;
    chk_idle("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare each predicted cycle against the DUT, away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.care_fwd) begin
          chk("ForwardAE", 32'(hif.ForwardAE), e.fa);
          chk("ForwardBE", 32'(hif.ForwardBE), e.fb);
        end
        chk("StallF", 32'(hif.StallF), e.sf);
        chk("StallD", 32'(hif.StallD), e.sd);
        chk("FlushD", 32'(hif.FlushD), e.fd);
        chk("FlushE", 32'(hif.FlushE), e.fe);
        chk("stall_cnt", 32'(hif.stall_cnt), e.sc);
        chk("flush_cnt", 32'(hif.flush_cnt), e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int regs [6] = '{0, 1, 2, 3, 14, 15};
    rst_n = 1'b0;
    drive_zero();
    model_clear();
    repeat (2) @(negedge clk);
    #3;
    chk_idle("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD R1 then SUB R2,R1,R3: M forward, for one cycle only
    step(2, 3, 1, 1, 0, 0, 0, 1, 0);
    step(1, 3, 2, 1, 0, 0, 0, 1, 0);
    nop(); #3 chk("fwd_mem", 32'(hif.ForwardAE), 2);
    nop(); #3 chk("fwd_mem_once", 32'(hif.ForwardAE), 0);
    // one instruction between: W forward
    step(2, 3, 1, 1, 0, 0, 0, 1, 0);
    nop();
    step(1, 3, 2, 1, 0, 0, 0, 1, 0);
    nop(); #3 chk("fwd_wb", 32'(hif.ForwardAE), 1);

    // LDR R4 then ADD R5,R4,R4: one bubble, then W forward on both operands
    step(0, 0, 4, 1, 1, 0, 0, 1, 0);
    step(4, 4, 5, 1, 0, 0, 0, 1, 0);
    #3 chk("lu_stallF", 32'(hif.StallF), 1);
    chk("lu_stallD", 32'(hif.StallD), 1);
    chk("lu_flushE", 32'(hif.FlushE), 1);
    step(4, 4, 5, 1, 0, 0, 0, 1, 0);
    #3 chk("lu_one_bubble", 32'(hif.StallD), 0);
    nop();
    #3 chk("lu_fwdA", 32'(hif.ForwardAE), 1);
    chk("lu_fwdB", 32'(hif.ForwardBE), 1);
    chk("lu_stall_cnt", 32'(hif.stall_cnt), 1);
    chk("lu_flush_cnt", 32'(hif.flush_cnt), 1);

    // taken branch during a load-use stall
    step(0, 0, 4, 1, 1, 0, 0, 1, 0);
    step(4, 4, 5, 1, 0, 0, 0, 1, 1);
    #3 chk("br_stallD", 32'(hif.StallD), 0);
    chk("br_flushD", 32'(hif.FlushD), 1);
    chk("br_flushE", 32'(hif.FlushE), 1);
    chk("br_stallF", 32'(hif.StallF), 1);
    nop();
    #3 chk("br_flush_cnt", 32'(hif.flush_cnt), 2);

    // MOV PC,R2: D flushed for four cycles, F held while the write is ahead of W
    step(0, 2, 15, 1, 0, 1, 0, 1, 0);
    #3 chk("pc_c1_flushD", 32'(hif.FlushD), 1);
    chk("pc_c1_stallF", 32'(hif.StallF), 1);
    for (int c = 2; c <= 4; c++) begin
      nop();
      #3 chk($sformatf("pc_c%0d_flushD", c), 32'(hif.FlushD), 1);
      if (c < 4) chk($sformatf("pc_c%0d_stallF", c), 32'(hif.StallF), 1);
    end
    nop();
    #3 chk("pc_done_flushD", 32'(hif.FlushD), 0);
    chk("pc_done_stallF", 32'(hif.StallF), 0);

    // ADDNE R1 with failed condition, then a use of R1
    step(2, 3, 1, 1, 0, 0, 0, 1, 0);
    step(1, 3, 2, 1, 0, 0, 0, 0, 0);
    nop();
    #3 chk("condfail_fwd", 32'(hif.ForwardAE), 0);
    chk("condfail_stall", 32'(hif.StallD), 0);
    // BL then a use of R14
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(14, 0, 3, 1, 0, 0, 0, 1, 0);
    nop();
    #3 chk("bl_fwd_lr", 32'(hif.ForwardAE), 2);
    // a producer of R15 is never forwarded
    step(0, 0, 15, 1, 0, 0, 0, 1, 0);
    step(15, 0, 3, 1, 0, 0, 0, 1, 0);
    nop();
    #3 chk("pc_no_fwd", 32'(hif.ForwardAE), 0);

    // 17 load-use stalls with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 4, 1, 1, 0, 0, 1, 0);
      step(4, 4, 5, 1, 0, 0, 0, 1, 0);
      step(4, 4, 5, 1, 0, 0, 0, 1, 0);
    end
    nop();
    #3 chk("stall_cnt_sat", 32'(hif.stall_cnt), CNT_MAX);

    // asynchronous reset in the middle of a stall
    step(0, 0, 4, 1, 1, 0, 0, 1, 0);
    step(4, 4, 5, 1, 0, 0, 0, 1, 0);
    #3 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit ld;
      ld = ($urandom_range(0, 3) == 0);
      step(regs[$urandom_range(0, 5)], regs[$urandom_range(0, 5)], regs[$urandom_range(0, 5)],
           ld || ($urandom_range(0, 1) == 1), ld, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    #3 chk("drain", 32'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
